alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Registered operand-select stage for the multicycle datapath, sitting between the register file/sign-extend logic and the ALU.
- Selects ALU operand A (pc or register A) and operand B (register B, constant increment, sign-extended immediate, or shifted immediate).
- Holds both operands in a one-entry pipeline register with a valid/ready handshake, plus flush and a stall-cycle counter.
- Generalises the fixed 32-bit B-source mux in width, increment constant and immediate shift amount.

Parameters:
- WIDTH, 32, data width of all operands.
- PC_INC, 4, constant driven on operand B when sel_b = 2'b01.
- IMM_SHIFT, 2, left-shift amount applied to imm for sel_b = 2'b11; legal range 0..WIDTH-1.
- CNT_W, 8, width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  drop the held operand pair.
- in_valid  input  1  upstream presents operands and selects.
- in_ready  output  1  stage can accept this cycle.
- sel_a  input  1  0 selects reg_a, 1 selects pc.
- sel_b  input  2  00 reg_b, 01 PC_INC, 10 imm, 11 imm<<IMM_SHIFT.
- pc  input  WIDTH  program counter.
- reg_a  input  WIDTH  register A value.
- reg_b  input  WIDTH  register B value.
- imm  input  WIDTH  sign-extended immediate.
- out_valid  output  1  op_a/op_b hold a valid pair.
- out_ready  input  1  ALU consumes the pair this cycle.
- op_a  output  WIDTH  registered operand A.
- op_b  output  WIDTH  registered operand B.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (reset=1 at a clock edge): out_valid=0, op_a=0, op_b=0, stall_cnt=0. Reset has priority over all other inputs.
- in_ready = !out_valid || out_ready. It is combinational and is forced to 0 while reset=1.
- Capture: when in_valid && in_ready && !flush, op_a/op_b load the selected values at the next edge and out_valid=1. Latency is 1 cycle from accept to out_valid.
- Operand B selection:
  - sel_b=01 gives PC_INC zero-extended to WIDTH.
  - sel_b=11 gives imm shifted left by IMM_SHIFT. The shift is logical: low bits are zero-filled and bits shifted past WIDTH-1 are discarded.
- Consume without capture: out_valid && out_ready && !(in_valid && in_ready) sets out_valid to 0 next edge.
- Simultaneous consume and capture: the new pair replaces the old one with no bubble; out_valid stays 1.
- No consume: while out_valid && !out_ready, op_a, op_b and out_valid hold. Input changes are ignored.
- Flush (priority below reset): out_valid=0 next edge. Any capture in that cycle is dropped, and op_a/op_b keep their old values. in_ready is unaffected by flush.
- stall_cnt:
  - Increments on each edge where out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Control FSM states:
  - EMPTY (out_valid=0): goes to FULL on capture.
  - FULL (out_valid=1): goes to EMPTY on consume-without-capture or on flush; otherwise stays FULL.

Optional Feature:
- Macro: ALU_OPERAND_STAGE_FWD_EN.
- When defined, the block adds inputs fwd_valid (1), fwd_hit_a (1), fwd_hit_b (1) and fwd_data (WIDTH).
- On capture with fwd_valid=1:
  - If fwd_hit_a=1, op_a loads fwd_data instead of the sel_a selection.
  - If fwd_hit_b=1 and sel_b=00, op_b loads fwd_data. Forwarding is ignored for the other sel_b codes.
- When undefined, these ports do not exist and the selection is exactly as above.

Test Plan:
- Reset, then sel_a=1, pc=0x00400000, sel_b=01, in_valid=1, out_ready=1 -> next cycle out_valid=1, op_a=0x00400000, op_b=0x00000004.
- imm=0xFFFFFFFE, sel_b=11, sel_a=0, reg_a=0x12 -> op_b=0xFFFFFFF8, op_a=0x12. With sel_b=10 -> op_b=0xFFFFFFFE.
- Capture a pair, hold out_ready=0 for 300 cycles (CNT_W=8) while toggling the inputs -> op_a/op_b stable, in_ready=0, stall_cnt saturates at 255.
- Back-to-back: in_valid=1 and out_ready=1 every cycle, reg_b=1,2,3 on successive cycles -> op_b=1,2,3 on consecutive cycles, out_valid never drops.
- FULL, then flush=1 with in_valid=1 and reg_b=0x55 -> out_valid=0 next cycle, op_b keeps its old value. Also assert reset mid-stall -> all outputs 0 next cycle.
- With ALU_OPERAND_STAGE_FWD_EN: fwd_valid=1, fwd_hit_b=1, fwd_data=0xABCD, sel_b=00, reg_b=0x1 -> op_b=0xABCD. Same stimulus with sel_b=10 and imm=0x7 -> op_b=0x7.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
//------------------------------------------------------------------------------
// alu_operand_stage_if
// Handshake and operand bus between upstream select logic, the operand stage
// and the ALU. Forwarding signals exist only with ALU_OPERAND_STAGE_FWD_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             sel_a;
    logic [1:0]       sel_b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CNT_W-1:0] stall_cnt;
`ifdef ALU_OPERAND_STAGE_FWD_EN
    logic             fwd_valid;
    logic             fwd_hit_a;
    logic             fwd_hit_b;
    logic [WIDTH-1:0] fwd_data;

    modport master (
        output flush, in_valid, sel_a, sel_b, pc, reg_a, reg_b, imm, out_ready,
        output fwd_valid, fwd_hit_a, fwd_hit_b, fwd_data,
        input  in_ready, out_valid, op_a, op_b, stall_cnt
    );
    modport slave (
        input  flush, in_valid, sel_a, sel_b, pc, reg_a, reg_b, imm, out_ready,
        input  fwd_valid, fwd_hit_a, fwd_hit_b, fwd_data,
        output in_ready, out_valid, op_a, op_b, stall_cnt
    );
`else
    modport master (
        output flush, in_valid, sel_a, sel_b, pc, reg_a, reg_b, imm, out_ready,
        input  in_ready, out_valid, op_a, op_b, stall_cnt
    );
    modport slave (
        input  flush, in_valid, sel_a, sel_b, pc, reg_a, reg_b, imm, out_ready,
        output in_ready, out_valid, op_a, op_b, stall_cnt
    );
`endif
endinterface

`default_nettype wire

// File: rtl/alu_operand_stage.sv
//------------------------------------------------------------------------------
// alu_operand_stage
// Registered ALU operand select with one-entry valid/ready buffer, flush and a
// saturating stall counter. Optional forwarding: ALU_OPERAND_STAGE_FWD_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_operand_stage #(
    parameter int WIDTH     = 32,
    parameter int PC_INC    = 4,
    parameter int IMM_SHIFT = 2,
    parameter int CNT_W     = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_operand_stage_if.slave bus
);
    localparam logic [WIDTH-1:0] c_pc_inc = WIDTH'(PC_INC);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_in_ready;
    logic             w_capture;
    logic             w_stall;

    assign w_in_ready = !reset && ((r_state == EMPTY) || bus.out_ready);
    assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;
    assign w_stall    = (r_state == FULL) && !bus.out_ready && !bus.flush;

    always_comb begin
        w_sel_a = bus.sel_a ? bus.pc : bus.reg_a;
        case (bus.sel_b)
            2'b00:   w_sel_b = bus.reg_b;
            2'b01:   w_sel_b = c_pc_inc;
            2'b10:   w_sel_b = bus.imm;
            default: w_sel_b = bus.imm << IMM_SHIFT;
        endcase
`ifdef ALU_OPERAND_STAGE_FWD_EN
        // Forwarding overrides B only when B would have come from the register file
        if (bus.fwd_valid && bus.fwd_hit_a) begin
            w_sel_a = bus.fwd_data;
        end
        if (bus.fwd_valid && bus.fwd_hit_b && (bus.sel_b == 2'b00)) begin
            w_sel_b = bus.fwd_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_capture) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (bus.flush) begin
                    w_state_next = EMPTY;
                end else if (bus.out_ready && !w_capture) begin
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // Flush drops the capture but leaves the last operands in place
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_capture) begin
            r_op_a <= w_sel_a;
            r_op_b <= w_sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == FULL);
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
//------------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed and randomized checks of alu_operand_stage against a transaction model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_operand_stage;
    localparam int IMM_SHIFT = 2;
    localparam int CNT_MAX   = 255;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    // Transaction-level model: is a pair held, which pair, how many stalls seen
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_cnt;

    alu_operand_stage_if #(.WIDTH(32), .CNT_W(8)) bus ();

    alu_operand_stage #(
        .WIDTH    (32),
        .PC_INC   (4),
        .IMM_SHIFT(IMM_SHIFT),
        .CNT_W    (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_b(logic [1:0] sel, logic [31:0] rb, logic [31:0] im);
        logic [63:0] wide;
        case (sel)
            2'd0:    return rb;
            2'd1:    return 32'd4;
            2'd2:    return im;
            default: begin
                wide = {32'd0, im} * (64'd1 << IMM_SHIFT);
                return wide[31:0];
            end
        endcase
    endfunction

    function automatic logic exp_ready();
        return !reset && (!m_valid || bus.out_ready);
    endfunction

    task automatic model_edge();
        logic        acc;
        logic [31:0] a;
        logic [31:0] b;
        a = bus.sel_a ? bus.pc : bus.reg_a;
        b = exp_b(bus.sel_b, bus.reg_b, bus.imm);
`ifdef ALU_OPERAND_STAGE_FWD_EN
        if (bus.fwd_valid && bus.fwd_hit_a) a = bus.fwd_data;
        if (bus.fwd_valid && bus.fwd_hit_b && bus.sel_b == 2'd0) b = bus.fwd_data;
`endif
        if (reset) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_cnt = 0;
        end else begin
            acc = bus.in_valid && exp_ready() && !bus.flush;
            if (m_valid && !bus.out_ready && !bus.flush && m_cnt < CNT_MAX) m_cnt++;
            if (bus.flush) m_valid = 1'b0;
            else if (acc) begin m_valid = 1'b1; m_a = a; m_b = b; end
            else if (bus.out_ready) m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.sel_a = 0; bus.sel_b = 0;
        bus.pc = 0; bus.reg_a = 0; bus.reg_b = 0; bus.imm = 0; bus.out_ready = 0;
`ifdef ALU_OPERAND_STAGE_FWD_EN
        bus.fwd_valid = 0; bus.fwd_hit_a = 0; bus.fwd_hit_b = 0; bus.fwd_data = 0;
`endif
    endtask

    task automatic test_reset();
        reset = 1; bus.in_valid = 1; bus.out_ready = 1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.op_a !== 32'd0 || bus.op_b !== 32'd0 || bus.stall_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_state got v=%b a=%h b=%h c=%0d exp all 0", bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt);
        end
        reset = 0; bus.in_valid = 0;
    endtask

    task automatic test_capture();
        bus.sel_a = 1; bus.pc = 32'h0040_0000; bus.sel_b = 2'b01; bus.in_valid = 1; bus.out_ready = 1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.op_a !== 32'h0040_0000 || bus.op_b !== 32'h4) begin
            n_errors++;
            $display("FAIL capture_pc_inc got v=%b a=%h b=%h exp v=1 a=00400000 b=00000004", bus.out_valid, bus.op_a, bus.op_b);
        end
    endtask

    task automatic test_imm();
        bus.sel_a = 0; bus.reg_a = 32'h12; bus.imm = 32'hFFFF_FFFE; bus.sel_b = 2'b11;
        bus.in_valid = 1; bus.out_ready = 1;
        tick();
        n_checks++;
        if (bus.op_b !== 32'hFFFF_FFF8 || bus.op_a !== 32'h12) begin
            n_errors++; $display("FAIL imm_shift got a=%h b=%h exp a=00000012 b=fffffff8", bus.op_a, bus.op_b);
        end
        bus.sel_b = 2'b10;
        tick();
        n_checks++;
        if (bus.op_b !== 32'hFFFF_FFFE) begin
            n_errors++; $display("FAIL imm_plain got b=%h exp b=fffffffe", bus.op_b);
        end
    endtask

    task automatic test_stall();
        logic [31:0] ka;
        logic [31:0] kb;
        bus.sel_a = 0; bus.reg_a = 32'hCAFE_0001; bus.sel_b = 0; bus.reg_b = 32'hBEEF_0002;
        bus.in_valid = 1; bus.out_ready = 1;
        tick();
        ka = 32'hCAFE_0001; kb = 32'hBEEF_0002;
        bus.out_ready = 0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'($urandom); bus.sel_a = 1'($urandom); bus.sel_b = 2'($urandom);
            bus.pc = $urandom; bus.reg_a = $urandom; bus.reg_b = $urandom; bus.imm = $urandom;
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.op_a !== ka || bus.op_b !== kb || bus.stall_cnt !== 8'(m_cnt)) begin
                n_errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b a=%h b=%h c=%0d exp v=1 a=%h b=%h c=%0d",
                         i, bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt, ka, kb, m_cnt);
            end
        end
        n_checks++;
        if (bus.stall_cnt !== 8'd255) begin n_errors++; $display("FAIL stall_saturate got=%0d exp=255", bus.stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        reset = 1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.op_a !== 32'd0 || bus.op_b !== 32'd0 || bus.stall_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_mid_stall got v=%b a=%h b=%h c=%0d exp all 0", bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt);
        end
        reset = 0;
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1; bus.out_ready = 1; bus.sel_b = 0; bus.flush = 0;
        for (int i = 1; i <= 3; i++) begin
            bus.reg_b = 32'(i);
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.op_b !== 32'(i)) begin
                n_errors++; $display("FAIL back_to_back step=%0d got v=%b b=%h exp v=1 b=%h", i, bus.out_valid, bus.op_b, 32'(i));
            end
        end
    endtask

    task automatic test_flush();
        bus.in_valid = 1; bus.out_ready = 1; bus.sel_b = 0; bus.reg_b = 32'h77;
        tick();
        bus.flush = 1; bus.reg_b = 32'h55;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.op_b !== 32'h77) begin
            n_errors++; $display("FAIL flush_drop got v=%b b=%h exp v=0 b=00000077", bus.out_valid, bus.op_b);
        end
        bus.flush = 0; bus.in_valid = 0;
    endtask

`ifdef ALU_OPERAND_STAGE_FWD_EN
    task automatic test_fwd();
        bus.in_valid = 1; bus.out_ready = 1; bus.fwd_valid = 1; bus.fwd_hit_b = 1; bus.fwd_hit_a = 0;
        bus.fwd_data = 32'hABCD; bus.sel_b = 2'b00; bus.reg_b = 32'h1;
        tick();
        n_checks++;
        if (bus.op_b !== 32'hABCD) begin n_errors++; $display("FAIL fwd_b got=%h exp=0000abcd", bus.op_b); end
        bus.sel_b = 2'b10; bus.imm = 32'h7;
        tick();
        n_checks++;
        if (bus.op_b !== 32'h7) begin n_errors++; $display("FAIL fwd_b_ignored got=%h exp=00000007", bus.op_b); end
        bus.fwd_valid = 0; bus.fwd_hit_b = 0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.in_valid = 1'($urandom); bus.out_ready = 1'($urandom);
            bus.sel_a = 1'($urandom); bus.sel_b = 2'($urandom);
            bus.pc = $urandom; bus.reg_a = $urandom; bus.reg_b = $urandom; bus.imm = $urandom;
`ifdef ALU_OPERAND_STAGE_FWD_EN
            bus.fwd_valid = 1'($urandom); bus.fwd_hit_a = 1'($urandom);
            bus.fwd_hit_b = 1'($urandom); bus.fwd_data = $urandom;
`endif
            #1;
            n_checks++;
            if (bus.in_ready !== exp_ready()) begin
                n_errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, exp_ready());
            end
            tick();
            n_checks++;
            if (bus.out_valid !== m_valid || bus.op_a !== m_a || bus.op_b !== m_b || bus.stall_cnt !== 8'(m_cnt)) begin
                n_errors++;
                $display("FAIL rand_out cyc=%0d got v=%b a=%h b=%h c=%0d exp v=%b a=%h b=%h c=%0d",
                         i, bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt, m_valid, m_a, m_b, m_cnt);
            end
        end
        reset = 0; bus.flush = 0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_valid = 0; m_a = 0; m_b = 0; m_cnt = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_capture();
        test_imm();
        test_stall();
        test_reset_mid_stall();
        test_back_to_back();
        test_flush();
`ifdef ALU_OPERAND_STAGE_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
